// File: rtl/enemy_fleet_ctrl.sv
// Formation controller for the enemy row: shared origin, march cadence,
// edge bounce/drop, alive mask, kill accounting and landed/cleared status.
module enemy_fleet_ctrl #(
    parameter int unsigned N_ENEMIES   = 8,
    parameter int unsigned ENEMY_SIZE  = 40,
    parameter int unsigned PITCH       = 56,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned START_X     = 16,
    parameter int unsigned START_Y     = 40,
    parameter int unsigned STEP_X      = 2,
    parameter int unsigned DROP_Y      = 40,
    parameter int unsigned LAND_Y      = 429,
    parameter int unsigned PERIOD_INIT = 4,
    parameter int unsigned PERIOD_MIN  = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 frame_i,
    input  logic                 start_i,
    input  logic [N_ENEMIES-1:0] hit_i,
    output logic [9:0]           fleet_x_o,
    output logic [9:0]           fleet_y_o,
    output logic                 dir_o,
    output logic [N_ENEMIES-1:0] alive_o,
    output logic                 kill_o,
    output logic                 landed_o,
    output logic                 cleared_o,
    output logic [1:0]           state_o
);

    localparam int unsigned KILL_W = $clog2(N_ENEMIES + 1);
    localparam int unsigned CNT_W  = $clog2(PERIOD_INIT + 1);
    localparam int unsigned IDX_W  = $clog2(N_ENEMIES);
    localparam int unsigned GEO_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MARCH   = 2'd1,
        ST_LANDED  = 2'd2,
        ST_CLEARED = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [KILL_W-1:0]    kills, kills_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [CNT_W-1:0]     period;
    logic [9:0]           fleet_x_n, fleet_y_n;
    logic                 dir_n, kill_n, landed_n, cleared_n;
    logic [N_ENEMIES-1:0] alive_n, newly;
    logic [KILL_W-1:0]    pop;
    logic [IDX_W-1:0]     lo, hi;
    logic [GEO_W-1:0]     left_edge, right_edge;
    logic                 tick, bounce, land_hit;

    // Step period shrinks with kills, floored at PERIOD_MIN
    always_comb begin
        if (32'(kills) + PERIOD_MIN >= PERIOD_INIT) begin
            period = CNT_W'(PERIOD_MIN);
        end else begin
            period = CNT_W'(PERIOD_INIT - 32'(kills));
        end
    end

    // Lowest and highest live column from the registered mask
    always_comb begin
        lo = '0;
        hi = '0;
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            if (alive_o[i]) lo = IDX_W'(i);
        end
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (alive_o[i]) hi = IDX_W'(i);
        end
    end

    assign left_edge  = GEO_W'(fleet_x_o) + GEO_W'(lo) * GEO_W'(PITCH);
    assign right_edge = GEO_W'(fleet_x_o) + GEO_W'(hi) * GEO_W'(PITCH)
                      + GEO_W'(ENEMY_SIZE - 1);
    assign bounce     = dir_o ? (left_edge < GEO_W'(STEP_X))
                              : (right_edge + GEO_W'(STEP_X) > GEO_W'(H_RES - 1));
    assign land_hit   = (GEO_W'(fleet_y_o) + GEO_W'(DROP_Y) + GEO_W'(ENEMY_SIZE))
                      >= GEO_W'(LAND_Y);
    assign newly      = hit_i & alive_o;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            pop = pop + KILL_W'(newly[i]);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n   = state;
        fleet_x_n = fleet_x_o;
        fleet_y_n = fleet_y_o;
        dir_n     = dir_o;
        alive_n   = alive_o;
        kills_n   = kills;
        cnt_n     = cnt;
        kill_n    = 1'b0;
        landed_n  = landed_o;
        cleared_n = cleared_o;
        tick      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_i) state_n = ST_MARCH;
            end
            ST_MARCH: begin
                if (start_i) begin
                    fleet_x_n = 10'(START_X);
                    fleet_y_n = 10'(START_Y);
                    dir_n     = 1'b0;
                    alive_n   = '1;
                    kills_n   = '0;
                    cnt_n     = '0;
                    landed_n  = 1'b0;
                    cleared_n = 1'b0;
                end else begin
                    if (frame_i) begin
                        if (cnt == period - CNT_W'(1)) begin
                            tick  = 1'b1;
                            cnt_n = '0;
                        end else if (cnt >= period) begin
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                    if (tick) begin
                        if (bounce) begin
                            dir_n = ~dir_o;
                            if (land_hit) begin
                                fleet_y_n = 10'(LAND_Y - ENEMY_SIZE);
                                landed_n  = 1'b1;
                                state_n   = ST_LANDED;
                            end else begin
                                fleet_y_n = 10'(fleet_y_o + 10'(DROP_Y));
                            end
                        end else if (dir_o) begin
                            fleet_x_n = 10'(fleet_x_o - 10'(STEP_X));
                        end else begin
                            fleet_x_n = 10'(fleet_x_o + 10'(STEP_X));
                        end
                    end
                    alive_n = alive_o & ~newly;
                    kills_n = kills + pop;
                    kill_n  = |newly;
                    // Clearing the last enemy beats a same-cycle landing
                    if (alive_n == '0) begin
                        landed_n  = 1'b0;
                        cleared_n = 1'b1;
                        state_n   = ST_CLEARED;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    fleet_x_n = 10'(START_X);
                    fleet_y_n = 10'(START_Y);
                    dir_n     = 1'b0;
                    alive_n   = '1;
                    kills_n   = '0;
                    cnt_n     = '0;
                    landed_n  = 1'b0;
                    cleared_n = 1'b0;
                    state_n   = ST_MARCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state     <= ST_IDLE;
            fleet_x_o <= 10'(START_X);
            fleet_y_o <= 10'(START_Y);
            dir_o     <= 1'b0;
            alive_o   <= '1;
            kills     <= '0;
            cnt       <= '0;
            kill_o    <= 1'b0;
            landed_o  <= 1'b0;
            cleared_o <= 1'b0;
        end else begin
            state     <= state_n;
            fleet_x_o <= fleet_x_n;
            fleet_y_o <= fleet_y_n;
            dir_o     <= dir_n;
            alive_o   <= alive_n;
            kills     <= kills_n;
            cnt       <= cnt_n;
            kill_o    <= kill_n;
            landed_o  <= landed_n;
            cleared_o <= cleared_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// Directed bench for enemy_fleet_ctrl: vector table plus hand sequences for
// bounce, edge shrink, landing (second instance with LAND_Y=200) and clear.
module tb_enemy_fleet_ctrl;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       frame_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] hit_i = 8'h00;

    logic [9:0] fleet_x, fleet_y, l_x, l_y;
    logic       dir, kill, landed, cleared, l_dir, l_kill, l_landed, l_cleared;
    logic [7:0] alive, l_alive;
    logic [1:0] state, l_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enemy_fleet_ctrl u_dut (
        .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .start_i(start_i),
        .hit_i(hit_i), .fleet_x_o(fleet_x), .fleet_y_o(fleet_y), .dir_o(dir),
        .alive_o(alive), .kill_o(kill), .landed_o(landed), .cleared_o(cleared),
        .state_o(state)
    );

    enemy_fleet_ctrl #(.LAND_Y(200)) u_land (
        .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .start_i(start_i),
        .hit_i(hit_i), .fleet_x_o(l_x), .fleet_y_o(l_y), .dir_o(l_dir),
        .alive_o(l_alive), .kill_o(l_kill), .landed_o(l_landed),
        .cleared_o(l_cleared), .state_o(l_state)
    );

    typedef struct {
        logic       frame;
        logic       start;
        logic [7:0] hit;
        int         x;
        int         y;
        int         dir;
        logic [7:0] alive;
        int         kill;
        int         state;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic f, input logic s, input logic [7:0] h);
        frame_i = f;
        start_i = s;
        hit_i   = h;
        @(posedge clk);
        #1;
        frame_i = 1'b0;
        start_i = 1'b0;
        hit_i   = 8'h00;
    endtask

    task automatic tick4();
        repeat (4) cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        reset_i = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, int'(fleet_x), 16);
        chk({tag, "_y"}, int'(fleet_y), 40);
        chk({tag, "_dir"}, int'(dir), 0);
        chk({tag, "_alive"}, int'(alive), 8'hFF);
        chk({tag, "_kill"}, int'(kill), 0);
        chk({tag, "_landed"}, int'(landed), 0);
        chk({tag, "_cleared"}, int'(cleared), 0);
        chk({tag, "_state"}, int'(state), 0);
    endtask

    task automatic v(input logic f, input logic s, input logic [7:0] h, input int x,
                     input int y, input int d, input logic [7:0] a, input int k,
                     input int st);
        vec_t e;
        e.frame = f; e.start = s; e.hit = h; e.x = x; e.y = y; e.dir = d;
        e.alive = a; e.kill = k; e.state = st;
        vq.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cadence, single/dead hits, restart, counter wrap, speed-up
        v(0, 1, 8'h00, 16, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 16, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 16, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 16, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 18, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 18, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 18, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 18, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 20, 40, 0, 8'hFF, 0, 1);
        v(0, 0, 8'h00, 20, 40, 0, 8'hFF, 0, 1);
        v(0, 0, 8'h80, 20, 40, 0, 8'h7F, 1, 1);
        v(0, 0, 8'h00, 20, 40, 0, 8'h7F, 0, 1);
        v(0, 0, 8'h81, 20, 40, 0, 8'h7E, 1, 1);
        v(0, 0, 8'h01, 20, 40, 0, 8'h7E, 0, 1);
        v(0, 1, 8'h00, 16, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 16, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 16, 40, 0, 8'hFF, 0, 1);
        v(1, 0, 8'h00, 16, 40, 0, 8'hFF, 0, 1);
        v(0, 0, 8'h03, 16, 40, 0, 8'hFC, 1, 1);
        v(1, 0, 8'h00, 16, 40, 0, 8'hFC, 0, 1);
        v(1, 0, 8'h00, 16, 40, 0, 8'hFC, 0, 1);
        v(1, 0, 8'h00, 18, 40, 0, 8'hFC, 0, 1);
        v(1, 0, 8'h00, 18, 40, 0, 8'hFC, 0, 1);
        v(1, 0, 8'h00, 20, 40, 0, 8'hFC, 0, 1);
        v(0, 0, 8'h04, 20, 40, 0, 8'hF8, 1, 1);
        v(1, 0, 8'h00, 22, 40, 0, 8'hF8, 0, 1);
        v(1, 0, 8'h00, 24, 40, 0, 8'hF8, 0, 1);
        v(0, 0, 8'h01, 24, 40, 0, 8'hF8, 0, 1);
        v(1, 0, 8'h08, 26, 40, 0, 8'hF0, 1, 1);

        do_reset();
        chk_reset("reset");
        cyc(1'b1, 1'b0, 8'hFF);
        chk("idle_alive", int'(alive), 8'hFF);
        chk("idle_kill", int'(kill), 0);
        chk("idle_x", int'(fleet_x), 16);
        chk("idle_state", int'(state), 0);

        foreach (vq[i]) begin
            cyc(vq[i].frame, vq[i].start, vq[i].hit);
            chk($sformatf("v%0d_x", i), int'(fleet_x), vq[i].x);
            chk($sformatf("v%0d_y", i), int'(fleet_y), vq[i].y);
            chk($sformatf("v%0d_dir", i), int'(dir), vq[i].dir);
            chk($sformatf("v%0d_alive", i), int'(alive), int'(vq[i].alive));
            chk($sformatf("v%0d_kill", i), int'(kill), vq[i].kill);
            chk($sformatf("v%0d_state", i), int'(state), vq[i].state);
        end

        // Full-fleet right bounce, then landing on the LAND_Y=200 instance
        do_reset();
        cyc(1'b0, 1'b1, 8'h00);
        repeat (96) tick4();
        chk("rb_pre_x", int'(fleet_x), 208);
        chk("rb_pre_y", int'(fleet_y), 40);
        chk("rb_pre_dir", int'(dir), 0);
        tick4();
        chk("rb_x", int'(fleet_x), 208);
        chk("rb_y", int'(fleet_y), 80);
        chk("rb_dir", int'(dir), 1);
        chk("land1_y", int'(l_y), 80);
        repeat (104) tick4();
        chk("lb_pre_x", int'(fleet_x), 0);
        chk("lb_pre_dir", int'(dir), 1);
        tick4();
        chk("lb_x", int'(fleet_x), 0);
        chk("lb_y", int'(fleet_y), 120);
        chk("lb_dir", int'(dir), 0);
        chk("land2_y", int'(l_y), 120);
        chk("land2_state", int'(l_state), 1);
        repeat (104) tick4();
        tick4();
        chk("land3_y", int'(l_y), 160);
        chk("land3_landed", int'(l_landed), 1);
        chk("land3_state", int'(l_state), 2);
        chk("land3_dir", int'(l_dir), 1);
        chk("main3_y", int'(fleet_y), 160);
        chk("main3_state", int'(state), 1);
        chk("main3_landed", int'(landed), 0);
        repeat (8) tick4();
        chk("land_frozen_x", int'(l_x), 208);
        chk("land_frozen_y", int'(l_y), 160);
        chk("main_moving_x", int'(fleet_x), 192);
        cyc(1'b0, 1'b1, 8'h00);
        chk("land_reload_state", int'(l_state), 1);
        chk("land_reload_landed", int'(l_landed), 0);
        chk("land_reload_y", int'(l_y), 40);

        // Edge shrink: bounce moves out to x=264 once enemies 0 and 7 die
        do_reset();
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h80);
        chk("es_kill7", int'(kill), 1);
        chk("es_alive7", int'(alive), 8'h7F);
        cyc(1'b0, 1'b0, 8'h01);
        chk("es_alive0", int'(alive), 8'h7E);
        begin
            int n;
            n = 0;
            while (dir == 1'b0 && n < 3000) begin
                cyc(1'b1, 1'b0, 8'h00);
                n++;
            end
            chk("es_bounce_seen", int'(dir), 1);
        end
        chk("es_bounce_x", int'(fleet_x), 264);
        chk("es_bounce_y", int'(fleet_y), 80);

        // Clear with last two kills on a step tick, restart, then reset
        do_reset();
        cyc(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'(1 << i));
        chk("cl_alive6", int'(alive), 8'hC0);
        cyc(1'b1, 1'b0, 8'hC0);
        chk("cl_x", int'(fleet_x), 18);
        chk("cl_alive", int'(alive), 0);
        chk("cl_kill", int'(kill), 1);
        chk("cl_cleared", int'(cleared), 1);
        chk("cl_state", int'(state), 3);
        repeat (6) cyc(1'b1, 1'b0, 8'hFF);
        chk("cl_frozen_x", int'(fleet_x), 18);
        chk("cl_frozen_kill", int'(kill), 0);
        chk("cl_frozen_state", int'(state), 3);
        cyc(1'b0, 1'b1, 8'h00);
        chk("rs_x", int'(fleet_x), 16);
        chk("rs_alive", int'(alive), 8'hFF);
        chk("rs_cleared", int'(cleared), 0);
        chk("rs_state", int'(state), 1);
        repeat (8) cyc(1'b1, 1'b0, 8'h00);
        chk("rs_march_x", int'(fleet_x), 20);
        cyc(1'b0, 1'b0, 8'h02);
        reset_i = 1'b0;
        cyc(1'b1, 1'b1, 8'h01);
        reset_i = 1'b1;
        chk_reset("midreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
